// File: rtl/cache_axi_rd_mux.sv
// Round-robin read front end: N cache read ports onto one AXI4 AR/R master, R beats routed back by RID.
// AR goes out the cycle after the rd_rdy handshake and is held until arready; R path is combinational and never back-pressures.
module cache_axi_rd_mux #(
    parameter int N_PORTS    = 2,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_PORTS-1:0]      rd_req,
    input  logic [3*N_PORTS-1:0]    rd_type,
    input  logic [32*N_PORTS-1:0]   rd_addr,
    output logic [N_PORTS-1:0]      rd_rdy,
    output logic [N_PORTS-1:0]      ret_valid,
    output logic [N_PORTS-1:0]      ret_last,
    output logic [DATA_WIDTH-1:0]   ret_data,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [N_PORTS-1:0]      busy,
    output logic                    resp_err,
    output logic                    unexp_err
);
    localparam int          PW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * DATA_WIDTH / 8) - 32'd1);
    localparam logic [2:0]  LINE_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [N_PORTS-1:0]  elig;
    logic [N_PORTS-1:0]  grant;
    logic [N_PORTS-1:0]  rid_hit;
    logic [N_PORTS-1:0]  ar_set;
    logic [ID_WIDTH-1:0] gidx;
    logic [31:0]         gaddr;
    logic [2:0]          gtype;
    logic                found;
    logic                accept;
    logic                ar_hs;
    logic                line_req;

    assign elig = rd_req & ~busy;

    // Search order is ptr, ptr+1, ... with wrap; the first eligible port wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        gaddr = '0;
        gtype = '0;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!found && elig[i] && (i == (int'(ptr) + k) % N_PORTS)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gidx     = ID_WIDTH'(i);
                    gaddr    = rd_addr[32*i +: 32];
                    gtype    = rd_type[3*i +: 3];
                end
            end
        end
    end

    assign rd_rdy   = (state == IDLE) ? grant : '0;
    assign accept   = (state == IDLE) && found;
    assign line_req = (gtype == 3'b100);
    assign ar_hs    = arvalid && arready;
    assign arburst  = 2'b01;

    // A beat is only routed to a port that actually has a burst in flight.
    always_comb begin
        rid_hit = '0;
        ar_set  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            rid_hit[i] = busy[i] && (rid == ID_WIDTH'(i));
            ar_set[i]  = ar_hs && (arid == ID_WIDTH'(i));
        end
    end

    assign ret_valid = rid_hit & {N_PORTS{rvalid}};
    assign ret_last  = rid_hit & {N_PORTS{rvalid & rlast}};
    assign ret_data  = rdata;
    assign rready    = ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            ptr       <= '0;
            busy      <= '0;
            resp_err  <= 1'b0;
            unexp_err <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
        end else begin
            busy <= (busy & ~ret_last) | ar_set;
            if (rvalid && (rid_hit == '0))
                unexp_err <= 1'b1;
            if (rvalid && (rid_hit != '0) && (rresp != 2'b00))
                resp_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        arid    <= gidx;
                        araddr  <= line_req ? (gaddr & LINE_MASK) : gaddr;
                        arlen   <= line_req ? LINE_LEN : 8'd0;
                        arsize  <= line_req ? LINE_SIZE : {1'b0, gtype[1:0]};
                        arvalid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        ptr     <= PW'((int'(arid) + 1) % N_PORTS);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_rd_mux.sv
// Bench for cache_axi_rd_mux: table of single-port AR payloads, hand sequences for arbitration,
// stall, out-of-order return, error flags and reset; returned beats checked against a scoreboard queue.
module tb_cache_axi_rd_mux;
    localparam int N = 2, IDW = 4, DW = 32, LW = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   rd_req = '0;
    logic [3*N-1:0] rd_type = '0;
    logic [32*N-1:0] rd_addr = '0;
    logic [N-1:0]   rd_rdy, ret_valid, ret_last, busy;
    logic [DW-1:0]  ret_data;
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid, rready, resp_err, unexp_err;
    logic           arready = 1'b0;
    logic [IDW-1:0] rid = '0;
    logic [DW-1:0]  rdata = '0;
    logic [1:0]     rresp = '0;
    logic           rlast = 1'b0;
    logic           rvalid = 1'b0;

    cache_axi_rd_mux #(.N_PORTS(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clock(clock), .reset(reset), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .busy(busy),
        .resp_err(resp_err), .unexp_err(unexp_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [N-1:0] vld; logic [N-1:0] lst; logic [DW-1:0] dat; } beat_t;
    beat_t sb[$];

    typedef struct { int p; logic [2:0] t; logic [31:0] a; logic [31:0] ea; logic [7:0] el; logic [2:0] es; } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset && ret_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ret", 64'(ret_valid), 64'(0));
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("ret_valid", 64'(ret_valid), 64'(e.vld));
                check("ret_last", 64'(ret_last), 64'(e.lst));
                check("ret_data", 64'(ret_data), 64'(e.dat));
            end
        end
    end

    // Drives one R beat for a cycle; delivered beats are queued for the monitor.
    task automatic beat(input int id, input logic [DW-1:0] d, input logic last, input logic [1:0] resp, input bit deliver);
        beat_t e;
        rvalid = 1'b1; rid = IDW'(id); rdata = d; rlast = last; rresp = resp;
        if (deliver) begin
            e.vld = N'(1) << id;
            e.lst = last ? e.vld : '0;
            e.dat = d;
            sb.push_back(e);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic issue(input int p, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es);
        int n = 0;
        rd_type[3*p +: 3] = t;
        rd_addr[32*p +: 32] = a;
        rd_req[p] = 1'b1;
        @(negedge clock);
        while (!rd_rdy[p] && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rd_rdy_wait", 64'(rd_rdy[p]), 64'(1));
        tick();
        rd_req[p] = 1'b0;
        @(negedge clock);
        check("arvalid", 64'(arvalid), 64'(1));
        check("arid", 64'(arid), 64'(p));
        check("araddr", 64'(araddr), 64'(ea));
        check("arlen", 64'(arlen), 64'(el));
        check("arsize", 64'(arsize), 64'(es));
        check("arburst", 64'(arburst), 64'(1));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clock);
        check("busy_set", 64'(busy[p]), 64'(1));
        check("arvalid_drop", 64'(arvalid), 64'(0));
        tick();
    endtask

    task automatic burst(input int p, input int nb, input logic [DW-1:0] base);
        for (int b = 0; b < nb; b++)
            beat(p, base + DW'(b), (b == nb - 1), 2'b00, 1'b1);
        @(negedge clock);
        check("busy_clear", 64'(busy[p]), 64'(0));
        tick();
    endtask

    initial begin
        vt[0] = '{0, 3'b100, 32'h0000_0104, 32'h0000_0100, 8'd3, 3'd2};
        vt[1] = '{1, 3'b010, 32'h0000_0020, 32'h0000_0020, 8'd0, 3'd2};
        vt[2] = '{1, 3'b000, 32'h0000_0023, 32'h0000_0023, 8'd0, 3'd0};
        vt[3] = '{0, 3'b001, 32'h0000_0042, 32'h0000_0042, 8'd0, 3'd1};
        vt[4] = '{0, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 8'd3, 3'd2};
        vt[5] = '{1, 3'b100, 32'h1234_567C, 32'h1234_5670, 8'd3, 3'd2};

        repeat (3) tick();
        @(negedge clock);
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rd_rdy", 64'(rd_rdy), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_errs", 64'({resp_err, unexp_err}), 64'(0));
        check("rst_payload", 64'({arid, araddr, arlen, arsize}), 64'(0));
        check("rst_rready", 64'(rready), 64'(0));
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rready_on", 64'(rready), 64'(1));
        tick();

        for (int i = 0; i < 6; i++) begin
            issue(vt[i].p, vt[i].t, vt[i].a, vt[i].ea, vt[i].el, vt[i].es);
            burst(vt[i].p, int'(vt[i].el) + 1, 32'hA000_0000 + 32'(i * 16));
        end

        // Simultaneous requests with pointer at 0, then out-of-order return.
        rd_type = {3'b100, 3'b100};
        rd_addr = {32'h0000_0300, 32'h0000_0200};
        rd_req = 2'b11;
        @(negedge clock);
        check("rr_first", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req[0] = 1'b0;
        @(negedge clock);
        check("rr_arid0", 64'(arid), 64'(0));
        check("rr_addr0", 64'(araddr), 64'(32'h200));
        check("rd_rdy_issue", 64'(rd_rdy), 64'(0));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clock);
        check("rr_second", 64'(rd_rdy), 64'(2'b10));
        tick();
        rd_req[1] = 1'b0;
        @(negedge clock);
        check("rr_arid1", 64'(arid), 64'(1));
        check("rr_addr1", 64'(araddr), 64'(32'h300));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clock);
        check("rr_both_busy", 64'(busy), 64'(2'b11));
        tick();
        burst(1, LW, 32'hB100_0000);
        burst(0, LW, 32'hB000_0000);

        // AR stall: payload held, no rd_rdy; busy port is skipped; re-eligible the cycle after clear.
        rd_type = {3'b010, 3'b010};
        rd_addr = {32'h0000_0500, 32'h0000_0400};
        rd_req = 2'b11;
        @(negedge clock);
        check("ptr_back_to_0", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            check("stall_arvalid", 64'(arvalid), 64'(1));
            check("stall_payload", 64'({arid, araddr, arlen, arsize}), 64'({4'd0, 32'h400, 8'd0, 3'd2}));
            check("stall_rd_rdy", 64'(rd_rdy), 64'(0));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rd_req[0] = 1'b1;
        @(negedge clock);
        check("busy_port_skipped", 64'(rd_rdy), 64'(2'b10));
        tick();
        rd_req[1] = 1'b0;
        @(negedge clock);
        check("stall_arid1", 64'(arid), 64'(1));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clock);
        check("no_rdy_all_busy", 64'(rd_rdy), 64'(0));
        tick();
        beat(0, 32'hC000_0001, 1'b1, 2'b00, 1'b1);
        @(negedge clock);
        check("reeligible", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req[0] = 1'b0;
        @(negedge clock);
        check("reissue_arvalid", 64'(arvalid), 64'(1));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(1, 32'hC100_0001, 1'b1, 2'b00, 1'b1);
        beat(0, 32'hC000_0002, 1'b1, 2'b00, 1'b1);
        @(negedge clock);
        check("stall_busy_done", 64'(busy), 64'(0));
        tick();

        // Error flags.
        check("pre_errs", 64'({resp_err, unexp_err}), 64'(0));
        rvalid = 1'b1; rid = 4'd3; rlast = 1'b1; rdata = 32'hDEAD_0003;
        @(negedge clock);
        check("unexp_dropped", 64'(ret_valid), 64'(0));
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clock);
        check("unexp_err", 64'(unexp_err), 64'(1));
        check("resp_err_clean", 64'(resp_err), 64'(0));
        tick();
        issue(0, 3'b010, 32'h600, 32'h600, 8'd0, 3'd2);
        beat(0, 32'hE000_0000, 1'b1, 2'b10, 1'b1);
        repeat (3) tick();
        @(negedge clock);
        check("resp_err_sticky", 64'(resp_err), 64'(1));
        tick();

        // Reset with a burst in flight and an AR pending.
        issue(1, 3'b100, 32'h700, 32'h700, 8'd3, 3'd2);
        beat(1, 32'hF000_0000, 1'b0, 2'b00, 1'b1);
        beat(1, 32'hF000_0001, 1'b0, 2'b00, 1'b1);
        rd_type[2:0] = 3'b010;
        rd_addr[31:0] = 32'h800;
        rd_req[0] = 1'b1;
        tick();
        rd_req[0] = 1'b0;
        @(negedge clock);
        check("pre_reset_arvalid", 64'(arvalid), 64'(1));
        check("pre_reset_busy", 64'(busy), 64'(2'b10));
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rready_in_reset", 64'(rready), 64'(0));
        tick();
        @(negedge clock);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_arvalid", 64'(arvalid), 64'(0));
        check("reset_errs", 64'({resp_err, unexp_err}), 64'(0));
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rready_after", 64'(rready), 64'(1));
        check("sb_drained", 64'(sb.size()), 64'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
